// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the three-port memory arbiter.
package mem_arbiter_pkg;

  localparam int AW_DEFAULT = 10;
  localparam int DW_DEFAULT = 32;
  localparam int N_PORTS    = 3;

  // Arbiter FSM: no access outstanding / read in flight / read data returned
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RDWAIT = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Owner codes double as bit positions in the grant vector
  typedef enum logic [1:0] {
    OWN_IF  = 2'd0,
    OWN_LS  = 2'd1,
    OWN_DBG = 2'd2
  } owner_e;

  // Convert a one-hot grant vector (bit index = owner code) to an owner code
  function automatic owner_e gnt_to_owner(input logic [N_PORTS-1:0] gnt);
    if (gnt[OWN_LS])  return OWN_LS;
    if (gnt[OWN_DBG]) return OWN_DBG;
    return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter_prio.sv
// Priority selection with instruction-fetch starvation protection.
// Only state here is the 3-bit starvation counter; selection is combinational.
module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,        // FSM can accept a new command this cycle
  input  logic               i_if_req,
  input  logic               i_ls_req,
  input  logic               i_dbg_req,
  input  logic               i_halted,
  output logic [N_PORTS-1:0] o_gnt        // indexed by owner code
);

  logic [2:0] r_starve;
  logic       w_starved;
  logic       w_dbg_ok;

  assign w_starved = (r_starve >= 3'(MAX_WAIT));
  assign w_dbg_ok  = i_dbg_req && i_halted;

  // Starvation counter: counts cycles fetch waits, clears when fetch wins, saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 3'd0;
    end else if (o_gnt[OWN_IF]) begin
      r_starve <= 3'd0;
    end else if (i_if_req && (r_starve != 3'd7)) begin
      r_starve <= r_starve + 3'd1;
    end
  end

  // Grant selection: starved fetch first, then ls > dbg (only when halted) > if
  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      if (i_if_req && w_starved) begin
        o_gnt[OWN_IF] = 1'b1;
      end else if (i_ls_req) begin
        o_gnt[OWN_LS] = 1'b1;
      end else if (w_dbg_ok) begin
        o_gnt[OWN_DBG] = 1'b1;
      end else if (i_if_req) begin
        o_gnt[OWN_IF] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch, load/store and debug ports onto one single-port memory.
// Commands are combinational in the grant cycle; reads return MEM_LAT cycles later.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int DW       = DW_DEFAULT,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_ls_req,
  input  logic          i_ls_we,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [DW-1:0] i_ls_wdata,
  output logic          o_ls_gnt,
  output logic          o_ls_rvalid,
  output logic [DW-1:0] o_ls_rdata,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic          o_dbg_gnt,
  output logic          o_dbg_rvalid,
  output logic [DW-1:0] o_dbg_rdata,
  input  logic          i_halted,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  // Counter is loaded with MEM_LAT-1; zero means the data is due next cycle
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  arb_state_e         r_state, w_state_next;
  logic [1:0]         r_lat_cnt, w_lat_cnt_next;
  owner_e             r_owner, w_owner_next;
  logic [N_PORTS-1:0] w_gnt;
  logic [N_PORTS-1:0] w_rvalid;
  logic [DW-1:0]      w_rdata [N_PORTS];
  logic               w_grant_en;
  logic               w_mem_we;
  logic               w_rd_grant;

  // New commands only when nothing is in flight; reset masks all grants
  assign w_grant_en = rst_n && ((r_state == ST_IDLE) || (r_state == ST_RESP));

  arb_prio #(
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_grant_en),
    .i_if_req  (i_if_req),
    .i_ls_req  (i_ls_req),
    .i_dbg_req (i_dbg_req),
    .i_halted  (i_halted),
    .o_gnt     (w_gnt)
  );

  assign w_rd_grant = (|w_gnt) && !w_mem_we;

  // State register: FSM state, latency counter and read owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= 2'd0;
      r_owner   <= OWN_IF;
    end else begin
      r_state   <= w_state_next;
      r_lat_cnt <= w_lat_cnt_next;
      r_owner   <= w_owner_next;
    end
  end

  // Next state: a read grant starts the latency wait (skipped when MEM_LAT=1)
  always_comb begin
    w_state_next   = r_state;
    w_lat_cnt_next = r_lat_cnt;
    w_owner_next   = r_owner;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        w_state_next   = ST_IDLE;
        w_lat_cnt_next = 2'd0;
        if (w_rd_grant) begin
          w_owner_next   = gnt_to_owner(w_gnt);
          w_lat_cnt_next = LAT_INIT;
          w_state_next   = (LAT_INIT == 2'd0) ? ST_RESP : ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        w_lat_cnt_next = r_lat_cnt - 2'd1;
        if (r_lat_cnt <= 2'd1) begin
          w_lat_cnt_next = 2'd0;
          w_state_next   = ST_RESP;
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_lat_cnt_next = 2'd0;
      end
    endcase
  end

  // Outputs: steer the granted port's command onto the memory bus
  always_comb begin
    o_mem_en    = |w_gnt;
    w_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_gnt[OWN_LS]) begin
      w_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_we ? i_ls_wdata : '0;
    end else if (w_gnt[OWN_DBG]) begin
      w_mem_we    = i_dbg_we;
      o_mem_addr  = i_dbg_addr;
      o_mem_wdata = i_dbg_we ? i_dbg_wdata : '0;
    end else if (w_gnt[OWN_IF]) begin
      o_mem_addr  = i_if_addr;
    end
    o_mem_we = w_mem_we;
  end

  // Response fan-out: only the recorded owner sees rvalid and data
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_resp
    assign w_rvalid[gi] = rst_n && (r_state == ST_RESP) && (r_owner == owner_e'(gi));
    assign w_rdata[gi]  = w_rvalid[gi] ? i_mem_rdata : '0;
  end

  assign o_if_gnt     = w_gnt[OWN_IF];
  assign o_ls_gnt     = w_gnt[OWN_LS];
  assign o_dbg_gnt    = w_gnt[OWN_DBG];
  assign o_if_rvalid  = w_rvalid[OWN_IF];
  assign o_ls_rvalid  = w_rvalid[OWN_LS];
  assign o_dbg_rvalid = w_rvalid[OWN_DBG];
  assign o_if_rdata   = w_rdata[OWN_IF];
  assign o_ls_rdata   = w_rdata[OWN_LS];
  assign o_dbg_rdata  = w_rdata[OWN_DBG];

endmodule
